// File: rtl/dual_req_accum_sched_if.sv
// Requester-side handshake bundle: one instance per requester.
// The requester drives valid/op/dst/data and the scheduler answers with ready.
interface dual_req_accum_sched_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic             dst;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output op,
    output dst,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  op,
    input  dst,
    input  data,
    output ready
  );
endinterface

// File: rtl/dual_req_accum_sched.sv
// Round-robin scheduler sharing one add/sub datapath and two registers (a, b)
// between two requesters. Each accepted operation runs IDLE -> EXEC -> WB,
// so the block accepts at most one operation every three cycles.
module dual_req_accum_sched #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_req_accum_sched_if.slave req0,
  dual_req_accum_sched_if.slave req1,
  output logic [WIDTH-1:0]      a,
  output logic [WIDTH-1:0]      b,
  output logic                  c,
  output logic                  d,
  output logic                  done,
  output logic                  done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;

  state_t           state_q;
  logic             lastGrant_q;
  logic [1:0]       op_q;
  logic             dst_q;
  logic [WIDTH-1:0] data_q;
  logic             id_q;
  logic [WIDTH:0]   result_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic             done_q;
  logic             doneId_q;

  logic             ready0_d;
  logic             ready1_d;
  logic [WIDTH-1:0] src_d;
  logic [WIDTH:0]   result_d;

  // Grant logic: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    ready0_d = 1'b0;
    ready1_d = 1'b0;
    if (state_q == IDLE) begin
      ready0_d = req0.valid && (!req1.valid || lastGrant_q);
      ready1_d = req1.valid && (!req0.valid || !lastGrant_q);
    end
  end

  assign req0.ready = ready0_d;
  assign req1.ready = ready1_d;

  // Shared adder/subtractor; the extra MSB carries the carry or borrow.
  always_comb begin
    src_d    = dst_q ? b_q : a_q;
    result_d = '0;
    case (op_q)
      OP_LOAD: result_d = {1'b0, data_q};
      OP_ADD:  result_d = {1'b0, src_d} + {1'b0, data_q};
      OP_SUB:  result_d = {1'b0, src_d} - {1'b0, data_q};
      default: result_d = '0;
    endcase
  end

  // Sequencer: accept in IDLE, compute in EXEC, write back and pulse done in WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      op_q        <= '0;
      dst_q       <= 1'b0;
      data_q      <= '0;
      id_q        <= 1'b0;
      result_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      done_q      <= 1'b0;
      doneId_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ready0_d || ready1_d) begin
            op_q        <= ready1_d ? req1.op   : req0.op;
            dst_q       <= ready1_d ? req1.dst  : req0.dst;
            data_q      <= ready1_d ? req1.data : req0.data;
            id_q        <= ready1_d;
            lastGrant_q <= ready1_d;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          doneId_q <= id_q;
          state_q  <= WB;
        end
        WB: begin
          if (dst_q) begin
            b_q <= result_q[WIDTH-1:0];
          end else begin
            a_q <= result_q[WIDTH-1:0];
          end
          if ((op_q == OP_ADD || op_q == OP_SUB) && result_q[WIDTH]) begin
            c_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign d       = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = doneId_q;

endmodule

// File: doc/dual_req_accum_sched.md
Name: dual_req_accum_sched

Overview:
- Scheduler that shares one accumulator datapath between two requesters.
- The datapath is two WIDTH-bit registers, a and b, plus a single adder/subtractor.
- The block arbitrates round-robin between requester 0 and requester 1, sequences each accepted operation through a 3-state FSM, and reports completion and a sticky carry flag.
- Sits beneath the generated top-level flow logic, replacing per-flow private adders.

Parameters:
- WIDTH, 8, data width of operands and of registers a/b.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (rst==0 resets).
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  00 load, 01 add, 10 sub, 11 clear.
- req0_dst  input  1  destination: 0 = a, 1 = b.
- req0_data  input  WIDTH  operand.
- req1_valid, req1_ready, req1_op, req1_dst, req1_data: same as requester 0.
- a  output  WIDTH  register a.
- b  output  WIDTH  register b.
- c  output  1  sticky carry/borrow flag.
- d  output  1  busy: FSM is not IDLE.
- done  output  1  one-cycle completion pulse.
- done_id  output  1  requester whose operation completed; valid while done=1.

Behaviour:
- Reset (rst==0, asynchronous): a=0, b=0, c=0, d=0, done=0, done_id=0, FSM=IDLE, last_grant=1, so requester 0 wins the first tie. Any in-flight operation is dropped and produces no done pulse.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - reqN_ready is combinational. It is 1 only for the granted requester, and only in IDLE.
  - Grant rules:
    - Only one valid: grant it.
    - Both valid: grant the requester != last_grant.
    - None valid: stay in IDLE.
  - On the accepting edge: latch op, dst, data and the grant id into internal registers; set last_grant to the grant id; go to EXEC.
- EXEC (1 cycle):
  - Compute a (WIDTH+1)-bit result from src = selected register (a or b):
    - load: {0, data}
    - add: src + data
    - sub: src - data, with the MSB meaning borrow
    - clear: 0
  - Register the result; go to WB.
- WB (1 cycle):
  - Write result[WIDTH-1:0] to the destination register.
  - If op is add or sub and result[WIDTH]==1, set c=1. c is never cleared except by reset.
  - done=1 and done_id=latched id for this cycle only.
  - Go to IDLE.
- Timing and throughput:
  - Latency: acceptance edge T, destination register updated at edge T+2, done high in the cycle following edge T+1.
  - Throughput: one operation per 3 cycles; the next acceptance can occur at edge T+3.
- Output d:
  - d=1 in EXEC and WB, d=0 in IDLE.
  - d is registered, i.e. derived from the FSM state register.
- Handshake rules:
  - A requester must hold valid and payload stable until it sees ready.
  - A valid that is dropped before ready is simply ignored.
- Arithmetic: all arithmetic wraps modulo 2^WIDTH. The non-destination register is never modified.
- Simultaneous events:
  - Requests arriving while d=1 wait; ready stays 0.
  - Two back-to-back ties alternate grants: 0,1,0,1...

Test Plan:
1. Release rst. req0: load 1 into a; then req1: load 0 into b. Required: a=1 and b=0 on the done cycle of the req1 operation; c=0; done_id sequence 0 then 1.
2. Both requesters hold valid continuously, each doing add 1 to its own register (req0->a, req1->b), starting from a=1, b=0, for 24 ops total. Required:
   - grants alternate 0,1,0,...
   - final a=13, b=12, c=0
   - ready never high while d=1
3. Load a=250, then add 10 to a. Required: a=4, c=1. Then sub 1 from b (b=0). Required: b=255, c stays 1.
4. Issue load 77 into b. Assert rst=0 asynchronously mid-EXEC (not on a clock edge). Required:
   - a, b, c, d, done go to 0 immediately
   - no done pulse after release
   - the first tie after release is granted to requester 0
5. Single requester 1 only, three ops back-to-back (load 5, add 7, sub 2 into a). Required:
   - accepts at edges 0, 3, 6
   - done pulses in the cycles after edges 1, 4, 7 with done_id=1
   - final a=10, b unchanged
6. req0 clear on b after b=23. Required: b=0, a unchanged, c unchanged.
